apb_master_arbiter: RTL and testbench

- Shares one APB3 master port between NREQ local requesters, e.g. test sequencers and a register-init engine driving the BFM-side APB fabric.
- Arbitrates round-robin and runs the APB SETUP/ACCESS sequence.
- Decodes the address into a 16-bit one-hot PSEL.
- Honours PREADY wait states and PSLVERR, and aborts hung transfers with a watchdog timeout.

---
 rtl/apb_master_arbiter.sv | 167 ++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB3 master port between NREQ local requesters. A round-robin
//   arbiter picks the next owner, latches its address/direction/write data,
//   and runs the APB SETUP/ACCESS handshake. The address is decoded into a
//   16-bit one-hot PSEL. PREADY wait states are honoured, PSLVERR is
//   reported, and a watchdog force-completes a transfer with an error after
//   TIMEOUT consecutive PREADY-low ACCESS cycles (TIMEOUT = 0 disables it).
//
// Ports
//   PCLK, PRESETN            clock (rising edge), async active-low reset
//   REQ/REQ_WRITE            per-requester request level and direction
//   REQ_ADDR/REQ_WDATA       per-requester address and write data, 32 bits each
//   GNT                      one-hot owner of the transfer in flight
//   ACK                      one-cycle completion pulse to the owner
//   RDATA/ERR                completion data and error, valid with ACK
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA            APB request outputs (all registered)
//   PRDATA/PREADY/PSLVERR    APB response inputs

module apb_master_arbiter #(
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 256,
  parameter int SLOT_LSB = 24
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    REQ_WRITE,
  input  logic [NREQ*32-1:0] REQ_ADDR,
  input  logic [NREQ*32-1:0] REQ_WDATA,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    ACK,
  output logic [31:0]        RDATA,
  output logic               ERR,
  output logic [31:0]        PADDR,
  output logic [15:0]        PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY,
  input  logic               PSLVERR
);

  localparam int PW   = $clog2(NREQ);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;
  logic [31:0]     pick_addr;
  logic [31:0]     pick_wdata;
  logic [3:0]      pick_slot;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  // Round-robin pick: scan downward from the farthest candidate so that the
  // last hit written is the first set bit at or after the pointer (with wrap).
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[(int'(ptr) + i) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  always_comb begin
    pick_addr  = REQ_ADDR[32*int'(pick_idx) +: 32];
    pick_wdata = REQ_WDATA[32*int'(pick_idx) +: 32];
    pick_slot  = pick_addr[SLOT_LSB +: 4];
  end

  // Watchdog fires on the TIMEOUT-th consecutive PREADY-low ACCESS cycle;
  // the counter holds the number of low cycles already seen.
  always_comb begin
    wd_expire = 1'b0;
    if (TIMEOUT != 0) begin
      wd_expire = !PREADY && (wd_cnt == WD_W'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (pick_valid) state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: if (PREADY || wd_expire) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Registered datapath and APB outputs. ACK defaults low each cycle so it
  // is high only in the DONE cycle that follows a completion.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      GNT     <= '0;
      ACK     <= '0;
      RDATA   <= '0;
      ERR     <= 1'b0;
      PADDR   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      owner   <= '0;
      ptr     <= '0;
      wd_cnt  <= '0;
    end else begin
      ACK <= '0;
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner  <= pick_idx;
            GNT    <= NREQ'(1) << pick_idx;
            PADDR  <= pick_addr;
            PWRITE <= REQ_WRITE[pick_idx];
            PWDATA <= pick_wdata;
            PSEL   <= 16'(1) << pick_slot;
          end
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (PREADY || wd_expire) begin
            RDATA   <= (PREADY && !PWRITE) ? PRDATA : 32'd0;
            ERR     <= PREADY ? PSLVERR : 1'b1;
            ACK     <= GNT;
            GNT     <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            wd_cnt  <= '0;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
//   Self-checking bench for apb_master_arbiter (NREQ=4, TIMEOUT=8,
//   SLOT_LSB=24). A simple APB slave responds with a configurable number of
//   wait states. Expected grants, PSEL, completion length and results come
//   from a transaction-level model of the arbitration and completion rules.

module tb_apb_master_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic               PCLK = 1'b0;
  logic               PRESETN;
  logic [NREQ-1:0]    REQ;
  logic [NREQ-1:0]    REQ_WRITE;
  logic [NREQ*32-1:0] REQ_ADDR;
  logic [NREQ*32-1:0] REQ_WDATA;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    ACK;
  logic [31:0]        RDATA;
  logic               ERR;
  logic [31:0]        PADDR;
  logic [15:0]        PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  apb_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TO), .SLOT_LSB(24)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .GNT(GNT), .ACK(ACK), .RDATA(RDATA), .ERR(ERR),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Requester-side stimulus and slave configuration
  logic [3:0]  req_vec;
  logic        req_wr    [NREQ];
  logic [31:0] req_addr  [NREQ];
  logic [31:0] req_wdata [NREQ];
  int          slv_wait;
  logic [31:0] slv_rdata;
  logic        slv_err;
  int          acc_cnt;
  int          mdl_ptr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          own;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        serr;
    logic [15:0] exp_psel;
    int          exp_len;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus();
    REQ = req_vec;
    for (int i = 0; i < NREQ; i++) begin
      REQ_WRITE[i]         = req_wr[i];
      REQ_ADDR[32*i +: 32]  = req_addr[i];
      REQ_WDATA[32*i +: 32] = req_wdata[i];
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_vec[i]   = 1'b1;
    apply_stimulus();
  endtask

  // Advance to the next falling edge and play the slave for the coming cycle.
  // Outside the ready cycle the response pins carry junk.
  task automatic step();
    @(negedge PCLK);
    if (PSEL != 16'd0 && PENABLE) begin
      PREADY = (acc_cnt >= slv_wait);
      acc_cnt++;
      if (PREADY) begin
        PRDATA  = slv_rdata;
        PSLVERR = slv_err;
      end else begin
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
    end else begin
      acc_cnt = 0;
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference model pieces
  function automatic int pick(input logic [3:0] m, input int p);
    logic [7:0] d;
    d = {m, m} >> p;
    for (int k = 0; k < 4; k++) if (d[k]) return (p + k) % 4;
    return 0;
  endfunction

  function automatic logic [15:0] slot_sel(input logic [31:0] addr);
    logic [3:0] s;
    s = addr[27:24];
    return 16'd1 << s;
  endfunction

  // One full transfer starting from an IDLE-cycle falling edge with the
  // request already driven; ends on the IDLE-cycle falling edge after DONE.
  task automatic run_txn(input int own, input logic [15:0] epsel, input int elen,
                         input logic [31:0] erd, input logic erf);
    logic [3:0] eg;
    eg = 4'd1 << own;
    step();
    check_output("setup_gnt", 32'(GNT), 32'(eg));
    check_output("setup_psel", 32'(PSEL), 32'(epsel));
    check_output("setup_penable", 32'(PENABLE), 32'd0);
    check_output("setup_paddr", PADDR, req_addr[own]);
    check_output("setup_pwrite", 32'(PWRITE), 32'(req_wr[own]));
    check_output("setup_pwdata", PWDATA, req_wdata[own]);
    for (int k = 0; k < elen; k++) begin
      step();
      check_output("access_psel", 32'(PSEL), 32'(epsel));
      check_output("access_penable", 32'(PENABLE), 32'd1);
      check_output("access_gnt", 32'(GNT), 32'(eg));
      check_output("access_ack", 32'(ACK), 32'd0);
    end
    step();
    check_output("done_ack", 32'(ACK), 32'(eg));
    check_output("done_rdata", RDATA, erd);
    check_output("done_err", 32'(ERR), 32'(erf));
    check_output("done_psel", 32'(PSEL), 32'd0);
    check_output("done_penable", 32'(PENABLE), 32'd0);
    check_output("done_gnt", 32'(GNT), 32'd0);
    check_output("done_paddr_kept", PADDR, req_addr[own]);
    req_vec[own] = 1'b0;
    apply_stimulus();
    mdl_ptr = (own + 1) % 4;
    step();
    check_output("idle_ack", 32'(ACK), 32'd0);
    check_output("idle_psel", 32'(PSEL), 32'd0);
  endtask

  // Expected results from the completion rules for the current slave setup.
  task automatic auto_txn(input int own);
    bit to;
    int len;
    logic [31:0] erd;
    logic erf;
    to  = (slv_wait >= TO);
    len = to ? TO : slv_wait + 1;
    erd = to ? 32'd0 : (req_wr[own] ? 32'd0 : slv_rdata);
    erf = to ? 1'b1 : slv_err;
    run_txn(own, slot_sel(req_addr[own]), len, erd, erf);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    vecs[0] = '{0, 1'b1, 32'h0300_0010, 32'hDEAD_BEEF, 0,   32'h5555_AAAA, 1'b0, 16'h0008, 1, 32'h0000_0000, 1'b0};
    vecs[1] = '{2, 1'b0, 32'h0500_0004, 32'h0000_0000, 3,   32'h1234_5678, 1'b0, 16'h0020, 4, 32'h1234_5678, 1'b0};
    vecs[2] = '{1, 1'b1, 32'h0F00_0000, 32'hCAFE_0001, 0,   32'h7777_7777, 1'b1, 16'h8000, 1, 32'h0000_0000, 1'b1};
    vecs[3] = '{1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1,   32'hA5A5_0F0F, 1'b0, 16'h0001, 2, 32'hA5A5_0F0F, 1'b0};
    vecs[4] = '{3, 1'b0, 32'h0700_0000, 32'h0000_0000, 100, 32'hFFFF_FFFF, 1'b0, 16'h0080, 8, 32'h0000_0000, 1'b1};
    vecs[5] = '{3, 1'b0, 32'hFA00_1234, 32'h0000_0000, 7,   32'h0BAD_F00D, 1'b1, 16'h0400, 8, 32'h0BAD_F00D, 1'b1};
    vecs[6] = '{0, 1'b1, 32'h0100_0000, 32'h0BB0_0BB0, 2,   32'h1357_9BDF, 1'b0, 16'h0002, 3, 32'h0000_0000, 1'b0};

    PRESETN  = 1'b0;
    req_vec  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_wr[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    apply_stimulus();
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    slv_wait = 0; slv_rdata = '0; slv_err = 1'b0; acc_cnt = 0; mdl_ptr = 0;

    // Reset state
    step();
    check_output("rst_gnt", 32'(GNT), 32'd0);
    check_output("rst_ack", 32'(ACK), 32'd0);
    check_output("rst_psel", 32'(PSEL), 32'd0);
    check_output("rst_penable", 32'(PENABLE), 32'd0);
    check_output("rst_pwrite", 32'(PWRITE), 32'd0);
    check_output("rst_err", 32'(ERR), 32'd0);
    check_output("rst_paddr", PADDR, 32'd0);
    check_output("rst_pwdata", PWDATA, 32'd0);
    check_output("rst_rdata", RDATA, 32'd0);
    step();
    PRESETN = 1'b1;

    // Contention from pointer 0: all four, each dropping after its ACK
    set_req(0, 1'b1, 32'h0100_0000, 32'hA0A0_0000);
    set_req(1, 1'b0, 32'h0200_0008, 32'h0);
    set_req(2, 1'b1, 32'h0900_000C, 32'h0000_2222);
    set_req(3, 1'b0, 32'h0C00_0010, 32'h0);
    slv_wait = 0; slv_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      slv_rdata = $urandom;
      auto_txn(k);
    end
    set_req(0, 1'b0, 32'h0600_0020, 32'h0);
    set_req(3, 1'b1, 32'h0D00_0030, 32'h3333_4444);
    slv_rdata = 32'h600D_0000;
    auto_txn(0);
    auto_txn(3);

    // Table-driven single-requester transfers
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].own, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      slv_wait  = vecs[v].waits;
      slv_rdata = vecs[v].prdata;
      slv_err   = vecs[v].serr;
      run_txn(vecs[v].own, vecs[v].exp_psel, vecs[v].exp_len, vecs[v].exp_rdata, vecs[v].exp_err);
    end

    // Reset mid-ACCESS; leave the pointer at 2 first so its reset is visible
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h4242_4242;
    set_req(1, 1'b0, 32'h0200_0040, 32'h0);
    auto_txn(1);
    set_req(3, 1'b1, 32'h0400_0000, 32'h1111_2222);
    slv_wait = 1000;
    step();
    step();
    step();
    check_output("pre_rst_psel", 32'(PSEL), 32'h0010);
    #2 PRESETN = 1'b0;
    #1;
    check_output("async_rst_psel", 32'(PSEL), 32'd0);
    check_output("async_rst_penable", 32'(PENABLE), 32'd0);
    check_output("async_rst_gnt", 32'(GNT), 32'd0);
    req_vec = 4'b1010;
    apply_stimulus();
    step();
    check_output("rst_hold_ack", 32'(ACK), 32'd0);
    step();
    check_output("rst_hold_gnt", 32'(GNT), 32'd0);
    PRESETN  = 1'b1;
    mdl_ptr  = 0;
    slv_wait = 0; slv_rdata = 32'h0000_5151;
    auto_txn(1);
    auto_txn(3);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      int own;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_vec[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      if (req_vec == 4'd0)
        set_req($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, $urandom);
      slv_wait  = $urandom_range(0, 10);
      slv_rdata = $urandom;
      slv_err   = 1'($urandom_range(0, 1));
      own = pick(req_vec, mdl_ptr);
      auto_txn(own);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
